// File: rtl/data_bus_arbiter.sv
// Two-master arbiter and access sequencer for the shared data/GPIO bus.
// Optional feature: define ARB_FIXED_PRIO_EN so that master 0 always wins ties (round-robin otherwise).
module data_bus_arbiter #(
  parameter int REG_WIDTH   = 32,
  parameter int WAIT_CYCLES = 1,
  parameter int MEM_TOP     = 128,
  parameter int GPIO_TOP    = 131
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req0,
  input  logic [REG_WIDTH-1:0] i_addr0,
  input  logic [REG_WIDTH-1:0] i_wdata0,
  input  logic                 i_we0,
  output logic                 o_ack0,
  output logic [REG_WIDTH-1:0] o_rdata0,
  input  logic                 i_req1,
  input  logic [REG_WIDTH-1:0] i_addr1,
  input  logic [REG_WIDTH-1:0] i_wdata1,
  input  logic                 i_we1,
  output logic                 o_ack1,
  output logic [REG_WIDTH-1:0] o_rdata1,
  output logic [REG_WIDTH-1:0] o_bus_addr,
  output logic [REG_WIDTH-1:0] o_bus_wdata,
  output logic                 o_bus_we,
  input  logic [REG_WIDTH-1:0] i_bus_rdata,
  output logic [1:0]           o_grant,
  output logic                 o_decerr
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] ACK    = 2'd2;

  localparam logic [REG_WIDTH-1:0] MEM_TOP_W  = REG_WIDTH'(MEM_TOP);
  localparam logic [REG_WIDTH-1:0] GPIO_TOP_W = REG_WIDTH'(GPIO_TOP);
  localparam logic [3:0]           COUNT_INIT = 4'(WAIT_CYCLES - 1);

  logic [1:0]           state;
  logic [3:0]           count;
  logic                 owner;
  logic                 acc_we;
  logic                 acc_mapped;
`ifndef ARB_FIXED_PRIO_EN
  logic                 last;
`endif

  logic                 pick1;
  logic [REG_WIDTH-1:0] sel_addr;
  logic [REG_WIDTH-1:0] sel_wdata;
  logic                 sel_we;
  logic                 sel_in_mem;
  logic                 sel_in_gpio;
  logic                 sel_mapped;
  logic [REG_WIDTH-1:0] capture;

  // On a tie the winner is the master that did not go last (or always master 0 in fixed mode).
  always_comb begin
    pick1 = 1'b0;
    if (i_req0 && i_req1) begin
`ifdef ARB_FIXED_PRIO_EN
      pick1 = 1'b0;
`else
      pick1 = ~last;
`endif
    end else begin
      pick1 = i_req1;
    end
  end

  always_comb begin
    sel_addr    = pick1 ? i_addr1  : i_addr0;
    sel_wdata   = pick1 ? i_wdata1 : i_wdata0;
    sel_we      = pick1 ? i_we1    : i_we0;
    sel_in_mem  = (sel_addr < MEM_TOP_W);
    sel_in_gpio = !sel_in_mem && (sel_addr < GPIO_TOP_W);
    sel_mapped  = sel_in_mem || sel_in_gpio;
  end

  // Writes and unmapped accesses return zero read data.
  always_comb begin
    capture = (acc_we || !acc_mapped) ? '0 : i_bus_rdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      count       <= 4'd0;
      owner       <= 1'b0;
      acc_we      <= 1'b0;
      acc_mapped  <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      last        <= 1'b1;
`endif
      o_ack0      <= 1'b0;
      o_ack1      <= 1'b0;
      o_rdata0    <= '0;
      o_rdata1    <= '0;
      o_bus_addr  <= '0;
      o_bus_wdata <= '0;
      o_bus_we    <= 1'b0;
      o_grant     <= 2'b00;
      o_decerr    <= 1'b0;
    end else begin
      o_ack0   <= 1'b0;
      o_ack1   <= 1'b0;
      o_decerr <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req0 || i_req1) begin
            o_bus_addr  <= sel_addr;
            o_bus_wdata <= sel_wdata;
            o_bus_we    <= sel_we && sel_mapped;
            o_grant     <= pick1 ? 2'b10 : 2'b01;
            owner       <= pick1;
            acc_we      <= sel_we;
            acc_mapped  <= sel_mapped;
`ifndef ARB_FIXED_PRIO_EN
            last        <= pick1;
`endif
            count       <= COUNT_INIT;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          if (count == 4'd0) begin
            if (owner) begin
              o_rdata1 <= capture;
              o_ack1   <= 1'b1;
            end else begin
              o_rdata0 <= capture;
              o_ack0   <= 1'b1;
            end
            o_decerr <= !acc_mapped;
            o_bus_we <= 1'b0;
            o_grant  <= 2'b00;
            state    <= ACK;
          end else begin
            count <= count - 4'd1;
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Scoreboard bench for data_bus_arbiter: per-master expectation queues checked on every ack.
module tb_data_bus_arbiter;

  localparam int W    = 32;
  localparam int WAIT = 3;
  localparam int GTOP = 131;

  typedef struct {
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    logic         we;
    logic [W-1:0] rdata;
    logic         decerr;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic         we0 = 1'b0, we1 = 1'b0;
  logic         ack0, ack1, bus_we, decerr;
  logic [W-1:0] rdata0, rdata1, bus_addr, bus_wdata, bus_rdata;
  logic [1:0]   grant;

  int   errors = 0;
  int   checks = 0;
  int   cycle = 0;
  int   gcount = 0;
  int   wecount = 0;
  logic [1:0] prev_grant = 2'b00;
  exp_t sb0[$];
  exp_t sb1[$];
  int   grant_log[$];
  int   grant_cyc[$];

  always #5 clk = ~clk;

  // Bus target model: read data is a fixed pattern of the address.
  assign bus_rdata = 32'hA5A5_0000 ^ bus_addr;

  data_bus_arbiter #(
    .REG_WIDTH(W), .WAIT_CYCLES(WAIT), .MEM_TOP(128), .GPIO_TOP(GTOP)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0(req0), .i_addr0(addr0), .i_wdata0(wdata0), .i_we0(we0),
    .o_ack0(ack0), .o_rdata0(rdata0),
    .i_req1(req1), .i_addr1(addr1), .i_wdata1(wdata1), .i_we1(we1),
    .o_ack1(ack1), .o_rdata1(rdata1),
    .o_bus_addr(bus_addr), .o_bus_wdata(bus_wdata), .o_bus_we(bus_we),
    .i_bus_rdata(bus_rdata), .o_grant(grant), .o_decerr(decerr)
  );

  task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  function automatic exp_t makeExp(input logic [W-1:0] a, input logic [W-1:0] d, input logic we);
    exp_t e;
    logic mapped;
    mapped   = (a < W'(GTOP));
    e.addr   = a;
    e.wdata  = d;
    e.we     = we;
    e.decerr = !mapped;
    e.rdata  = (we || !mapped) ? '0 : (32'hA5A5_0000 ^ a);
    return e;
  endfunction

  // Monitor: bus activity against the head of the owner's queue, ack results on pop.
  always @(negedge clk) begin
    exp_t e;
    logic m;
    cycle++;
    if (rst) begin
      gcount = 0;
      wecount = 0;
      prev_grant = 2'b00;
    end else begin
      if (grant != 2'b00) begin
        checkOutput("grant_onehot", W'(grant[0] & grant[1]), '0);
        m = grant[1];
        if (prev_grant == 2'b00) begin
          grant_log.push_back(int'(m));
          grant_cyc.push_back(cycle);
          gcount = 0;
          wecount = 0;
        end
        gcount++;
        if (bus_we) wecount++;
        if (m ? (sb1.size() != 0) : (sb0.size() != 0)) begin
          e = m ? sb1[0] : sb0[0];
          checkOutput("bus_addr", bus_addr, e.addr);
          checkOutput("bus_wdata", bus_wdata, e.wdata);
          checkOutput("bus_we", W'(bus_we), W'(e.we && !e.decerr));
        end
      end else begin
        checkOutput("bus_we_idle", W'(bus_we), '0);
      end
      if (ack0 || ack1) begin
        checkOutput("ack_onehot", W'(ack0 & ack1), '0);
        m = ack1;
        checkOutput("ack_has_expect", W'(m ? (sb1.size() != 0) : (sb0.size() != 0)), W'(1));
        if (m ? (sb1.size() != 0) : (sb0.size() != 0)) begin
          e = m ? sb1.pop_front() : sb0.pop_front();
          checkOutput(m ? "rdata1" : "rdata0", m ? rdata1 : rdata0, e.rdata);
          checkOutput("decerr", W'(decerr), W'(e.decerr));
          checkOutput("access_cycles", W'(gcount), W'(WAIT));
          checkOutput("we_cycles", W'(wecount), (e.we && !e.decerr) ? W'(WAIT) : '0);
        end
      end else begin
        checkOutput("decerr_no_ack", W'(decerr), '0);
      end
      prev_grant = grant;
    end
  end

  // One complete access by master m; req stays up until the ack is seen.
  task automatic applyStimulus(input bit m, input logic [W-1:0] a, input logic [W-1:0] d, input logic we);
    bit got;
    got = 1'b0;
    if (m) begin
      sb1.push_back(makeExp(a, d, we));
      addr1 = a; wdata1 = d; we1 = we; req1 = 1'b1;
    end else begin
      sb0.push_back(makeExp(a, d, we));
      addr0 = a; wdata0 = d; we0 = we; req0 = 1'b1;
    end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (m ? ack1 : ack0) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("ack_timeout", W'(got), W'(1));
    if (m) req1 = 1'b0;
    else   req0 = 1'b0;
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    sb0.delete();
    sb1.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_grant"}, W'(grant), '0);
    checkOutput({tag, "_acks"}, W'({ack0, ack1, decerr, bus_we}), '0);
    checkOutput({tag, "_addr"}, bus_addr, '0);
    checkOutput({tag, "_wdata"}, bus_wdata, '0);
    checkOutput({tag, "_rdata0"}, rdata0, '0);
    checkOutput({tag, "_rdata1"}, rdata1, '0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(1'b0, 32'd5, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'd127, 32'h1, 1'b1);
    applyStimulus(1'b1, 32'd128, 32'h1, 1'b1);
    applyStimulus(1'b1, 32'd130, 32'h1, 1'b1);
    checkOutput("rdata0_hold", rdata0, 32'hA5A5_0005);
    applyStimulus(1'b0, 32'd131, 32'hDEAD_BEEF, 1'b1);
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'd130, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'd128, 32'h0, 1'b0);

    // Contention from reset: both masters keep requesting.
    resetDut();
    grant_log.delete();
    grant_cyc.delete();
    fork
      begin
        applyStimulus(1'b0, 32'd10, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'd11, 32'h0, 1'b0);
      end
      begin
        applyStimulus(1'b1, 32'd20, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'd21, 32'h0, 1'b0);
      end
    join
    checkOutput("grant_count", W'(grant_log.size()), W'(4));
    if (grant_log.size() == 4) begin
`ifdef ARB_FIXED_PRIO_EN
      checkOutput("grant_order", W'({grant_log[0][0], grant_log[1][0], grant_log[2][0], grant_log[3][0]}), W'(4'b0011));
`else
      checkOutput("grant_order", W'({grant_log[0][0], grant_log[1][0], grant_log[2][0], grant_log[3][0]}), W'(4'b0101));
`endif
      for (int i = 1; i < 4; i++)
        checkOutput("grant_spacing", W'(grant_cyc[i] - grant_cyc[i-1]), W'(WAIT + 2));
    end

    // Reset in the second ACCESS cycle of a master 0 write.
    @(negedge clk);
    addr0 = 32'd20; wdata0 = 32'h55; we0 = 1'b1; req0 = 1'b1;
    @(negedge clk);
    checkOutput("abort_grant", W'(grant), W'(2'b01));
    checkOutput("abort_we", W'(bus_we), W'(1));
    @(negedge clk);
    rst = 1'b1;
    req0 = 1'b0;
    @(negedge clk);
    checkAllZero("abort");
    rst = 1'b0;
    repeat (WAIT + 4) @(negedge clk);
    checkOutput("abort_no_ack", W'({ack0, ack1}), '0);
    grant_log.delete();
    fork
      applyStimulus(1'b0, 32'd3, 32'h0, 1'b0);
      applyStimulus(1'b1, 32'd4, 32'h0, 1'b0);
    join
    checkOutput("tie_after_reset", W'(grant_log.size() != 0 ? grant_log[0] : 9), '0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
